// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with a one-byte holding register so that consecutive
// bytes leave back-to-back with no idle gap between frames.
module uart_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [7:0]       shift_q,      shift_d;
    logic [7:0]       hold_q,       hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             tx_q,         tx_d;
    logic             in_ready_q,   in_ready_d;

    logic accept;
    logic bit_end;

    assign accept  = in_valid && in_ready_q;
    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
            in_ready_q   <= in_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    shift_d = in_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        state_d      = START;
                    end else if (accept) begin
                        shift_d = in_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake outside IDLE parks the byte, except on the final STOP
        // edge where an empty hold lets it go straight into the shifter.
        if (accept && (state_q != IDLE) && !((state_q == STOP) && bit_end)) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end
    end

    always_comb begin
        tx_d       = 1'b1;
        in_ready_d = !hold_valid_d;
        busy       = (state_q != IDLE);
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx       = tx_q;
    assign in_ready = in_ready_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx at CLKS_PER_BIT=4: table-driven single frames,
// directed corner sequences and a random soak checked by a UART line decoder.
module tb_uart_byte_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 is sent first
    } vec_t;

    vec_t vecs[5];

    // Line decoder: hunts for a falling edge, then samples mid-bit.
    logic       dec_en = 1'b0;
    int         dec_phase = -1;
    logic [7:0] dec_byte = '0;
    int         dec_frame_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (!dec_en) begin
            dec_phase = -1;
        end else if (dec_phase < 0) begin
            if (tx === 1'b0) dec_phase = 0;
        end else begin
            dec_phase = dec_phase + 1;
            if ((dec_phase % CPB) == CPB / 2) begin
                if (dec_phase / CPB == 0) begin
                    if (tx !== 1'b0) dec_frame_err = dec_frame_err + 1;
                end else if (dec_phase / CPB <= 8) begin
                    dec_byte[dec_phase / CPB - 1] = tx;
                end else begin
                    if (tx !== 1'b1) dec_frame_err = dec_frame_err + 1;
                    rx_q.push_back(dec_byte);
                    dec_phase = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int unsigned idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return d[idx-1];
    endfunction

    task automatic check_idle(input string name);
        check({name, "_tx"}, tx, 1'b1);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] seq[3];
        logic       acc;
        int         wait_cnt;
        int         gap;

        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};
        vecs[4] = '{data: 8'h01, frame: 10'b1000000010};

        // Reset and idle
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("reset");
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_idle("idle");
        end

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            in_data = vecs[v].data;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int c = 0; c < 10 * CPB; c++) begin
                check("single_tx", tx, vecs[v].frame[c / CPB]);
                check("single_busy", busy, 1'b1);
                check("single_ready", in_ready, 1'b1);
                tick();
            end
            check_idle("single_end");
            tick();
        end

        // Back-to-back: 0x3C, 0xC3 into hold, 0xFF waiting for in_ready
        seq[0] = 8'h3C;
        seq[1] = 8'hC3;
        seq[2] = 8'hFF;
        in_data = seq[0];
        in_valid = 1'b1;
        tick();
        for (int c = 0; c < 30 * CPB; c++) begin
            logic exp_ready;
            exp_ready = (c == 0) || (c == 10 * CPB) || (c >= 20 * CPB);
            check("b2b_tx", tx, frame_bit(seq[c / (10 * CPB)], (c % (10 * CPB)) / CPB));
            check("b2b_busy", busy, 1'b1);
            check("b2b_ready", in_ready, exp_ready);
            if (c == 0) in_data = seq[1];
            if (c == 1) in_data = seq[2];
            if (c == 10 * CPB + 1) in_valid = 1'b0;
            tick();
        end
        check_idle("b2b_end");
        tick();

        // Offer on the last STOP edge with the hold empty
        seq[0] = 8'h5A;
        seq[1] = 8'h01;
        in_data = seq[0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 20 * CPB; c++) begin
            check("stopedge_tx", tx, frame_bit(seq[c / (10 * CPB)], (c % (10 * CPB)) / CPB));
            check("stopedge_busy", busy, 1'b1);
            check("stopedge_ready", in_ready, 1'b1);
            if (c == 10 * CPB - 1) begin
                in_data = seq[1];
                in_valid = 1'b1;
            end
            if (c == 10 * CPB) in_valid = 1'b0;
            tick();
        end
        check_idle("stopedge_end");
        tick();

        // Reset during data bit 3 of 0x55 with 0xAA held
        in_data = 8'h55;
        in_valid = 1'b1;
        tick();
        in_data = 8'hAA;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 4 * CPB + 1; c++) tick();
        check("midrst_bit3", tx, 1'b0);
        check("midrst_held", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrst_after");
        for (int c = 0; c < 15 * CPB; c++) begin
            tick();
            check("midrst_quiet_tx", tx, 1'b1);
            check("midrst_quiet_busy", busy, 1'b0);
        end

        // Reset wins over a handshake on the same edge
        rst = 1'b1;
        in_data = 8'h81;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 3 * CPB; c++) begin
            check("rstprio_tx", tx, 1'b1);
            check("rstprio_busy", busy, 1'b0);
            tick();
        end

        // Random soak
        dec_en = 1'b1;
        tick();
        for (int n = 0; n < 200; n++) begin
            gap = (($urandom % 8) == 0) ? int'($urandom_range(30, 60)) : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) tick();
            in_data = 8'($urandom);
            in_valid = 1'b1;
            acc = 1'b0;
            wait_cnt = 0;
            while (!acc && wait_cnt < 400) begin
                acc = in_ready;
                tick();
                wait_cnt++;
            end
            in_valid = 1'b0;
            check("soak_accept", acc, 1'b1);
            if (acc) exp_q.push_back(in_data);
        end
        wait_cnt = 0;
        while (busy && wait_cnt < 300) begin
            tick();
            wait_cnt++;
        end
        check("soak_drain", busy, 1'b0);
        for (int i = 0; i < 2 * CPB; i++) tick();
        dec_en = 1'b0;
        check("soak_frame_err", dec_frame_err, 0);
        check("soak_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check("soak_byte", rx_q[i], exp_q[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Serial output stage downstream of the top-level input-mixing logic, which combines `ui_in` and `uio_in` into one byte. Each byte it accepts is sent on a single pin as an 8N1 UART frame, which lets the tile's result be observed with a plain serial terminal. A one-byte holding register sits in front of the shift FSM, so back-to-back bytes are sent with no idle gap between frames. In the top level, `tx` drives `uo_out[0]` and `busy` drives `uo_out[1]`.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2 to 65535.

Ports:
- `clk`, input, 1: the single clock. All logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high. The top level drives it from `~rst_n`.
- `in_data`, input, 8: byte to transmit.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_ready`, output, 1: the block can accept a byte this cycle.
- `tx`, output, 1: serial line. It idles high.
- `busy`, output, 1: a frame is in progress.

## Operation

- FSM states are IDLE, START, DATA and STOP. `busy = (state != IDLE)`.
- Handshake:
  - A byte is accepted on a rising edge where `in_valid && in_ready`.
  - `in_data` is sampled only on that edge.
  - `in_ready` is registered and equals `!hold_valid`.
- Accept while in IDLE:
  - The byte loads directly into the shifter and the state goes to START.
  - `hold_valid` stays 0, so `in_ready` stays 1.
- Accept while in START, DATA or STOP:
  - The byte goes into the hold register and `hold_valid` becomes 1.
  - `in_ready` is 0 from the next cycle.
- Bit counter: `cnt` has width `$clog2(CLKS_PER_BIT)`. It counts 0 to `CLKS_PER_BIT-1` within each bit period.
- State sequence:
  - START drives `tx=0` for one bit period, then goes to DATA.
  - DATA drives `shift[0]` for one bit period per bit. It shifts right after each period, sending 8 bits LSB first. The 3-bit index `bit_idx` runs 0 to 7, and the state goes to STOP after bit 7.
  - STOP drives `tx=1` for one bit period.
- At the last cycle of STOP:
  - If `hold_valid` is 1: load the shifter from hold, clear `hold_valid`, and go straight to START with no idle cycle.
  - Else, if a handshake occurs on this edge: load `in_data` directly and go to START. This case is possible because `in_ready` is 1 whenever hold is empty.
  - Else: go to IDLE.
- `tx` is a registered output, so it is glitch-free.
- Reset:
  - Outputs after reset: `tx=1`, `in_ready=1`, `busy=0`. The state is IDLE, and `cnt`, `bit_idx` and `hold_valid` are 0.
  - Reset during a frame aborts it. `tx` is 1 from the cycle after the reset edge, and any held byte is discarded.
  - Reset has priority over a handshake on the same edge. The byte is not accepted.

## Timing

- Latency: a byte accepted on edge k in IDLE drives `tx=0` from just after edge k.
- Frame length: `10*CLKS_PER_BIT` cycles.
- Back-to-back throughput: one byte every `10*CLKS_PER_BIT` cycles, with no idle cycles between frames while hold is kept full.
- `busy` rises on the edge that starts START. It falls on the edge that ends STOP, and only if no next byte is pending.
- `in_ready` falls one edge after a hold load. It rises one edge after the hold is consumed at the end of STOP.
- A handshake cannot be lost. A byte offered while `in_ready=0` is not sampled, and the source must keep `in_valid` asserted until the handshake occurs.

## Test plan

All scenarios use `CLKS_PER_BIT=4`.
- Reset and idle:
  - Stimulus: hold `rst=1` for 3 cycles, then release; `in_valid=0`.
  - Required: `tx=1`, `in_ready=1`, `busy=0` throughout, with no transitions.
- Single byte:
  - Stimulus: accept 0xA5 in IDLE.
  - Required: `tx` reads 0, 1,0,1,0,0,1,0,1, 1, with each level held 4 cycles (40 cycles total).
  - Required: `busy` is high for exactly 40 cycles.
- Back-to-back:
  - Stimulus: accept 0x3C, then 0xC3 on the next edge.
  - Required: `in_ready` goes low after the second accept. It returns high on the edge where frame 1's STOP ends.
  - Required: frame 2's start bit begins immediately, making 80 contiguous busy cycles.
  - Required: a third byte 0xFF held valid throughout is accepted only then.
- Simultaneous at end of STOP:
  - Stimulus: hold empty, 0x01 offered exactly on the last STOP edge.
  - Required: 0x01's start bit follows with no idle cycle.
  - Required: `in_ready` stays 1.
- Reset mid-frame:
  - Stimulus: assert `rst` during data bit 3 of 0x55 with 0xAA held.
  - Required: next cycle `tx=1`, `busy=0`, `in_ready=1`.
  - Required: no further frame is sent; 0xAA is discarded.
- Random soak:
  - Stimulus: 200 random bytes with random `in_valid` gaps.
  - Required: a UART model recovers the exact byte sequence.
  - Required: no byte is accepted while `in_ready=0`.
